// File: rtl/sd_port_arbiter.sv
// N-port round-robin arbiter steering byte-stream masters onto one SD data-FIFO port.
// Latency: request-to-grant 1 cycle; datapath combinational from the registered owner.
// No backpressure: strobes from non-owners are discarded and flagged on drop_o.
module sd_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 512,
    parameter int TIMEOUT   = 1023,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    input  logic [NUM_PORTS-1:0]        rd_en_i,
    output logic [DATA_W-1:0]           rd_dat_o,
    input  logic [NUM_PORTS-1:0]        wr_en_i,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_dat_i,
    output logic                        sd_rd_en_o,
    input  logic [DATA_W-1:0]           sd_rd_dat_i,
    output logic                        sd_wr_en_o,
    output logic [DATA_W-1:0]           sd_wr_dat_o,
    output logic [PW-1:0]               owner_o,
    output logic                        busy_o,
    output logic                        drop_o,
    output logic                        timeout_o
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          last_q, last_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic                   drop_q, drop_d;

    logic                   busy;
    logic                   own_rd, own_wr, own_req;
    logic [DATA_W-1:0]      own_wdat;
    logic                   beat, burst_done, idle_expire;
    logic                   hi_vld, lo_vld;
    logic [PW-1:0]          hi_sel, lo_sel, sel;

    assign busy = (state_q == BUSY);

    // Pick out the owner's request, strobes and write data.
    always_comb begin
        own_rd   = 1'b0;
        own_wr   = 1'b0;
        own_req  = 1'b0;
        own_wdat = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (owner_q == PW'(k)) begin
                own_rd   = rd_en_i[k];
                own_wr   = wr_en_i[k];
                own_req  = req_i[k];
                own_wdat = wr_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Only the owner reaches the FIFO, and nobody does while idle.
    assign sd_rd_en_o  = busy & own_rd;
    assign sd_wr_en_o  = busy & own_wr;
    assign sd_wr_dat_o = busy ? own_wdat : '0;
    assign rd_dat_o    = sd_rd_dat_i;

    // A simultaneous read and write is a single beat.
    assign beat        = sd_rd_en_o | sd_wr_en_o;
    assign burst_done  = beat && (beat_q == BEAT_LAST);
    assign idle_expire = (TIMEOUT != 0) && busy && !beat && (idle_q == IDLE_LAST);

    // Round-robin pick: first requester above last, else first requester overall
    // (which then lies at or below last, completing the wrap-around scan).
    always_comb begin
        hi_vld = 1'b0;
        hi_sel = '0;
        lo_vld = 1'b0;
        lo_sel = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!hi_vld && req_i[j] && (PW'(j) > last_q)) begin
                hi_vld = 1'b1;
                hi_sel = PW'(j);
            end
            if (!lo_vld && req_i[j]) begin
                lo_vld = 1'b1;
                lo_sel = PW'(j);
            end
        end
        sel = hi_vld ? hi_sel : lo_sel;
    end

    // Strobes from anyone but the current owner are discarded and reported.
    assign drop_d = |((rd_en_i | wr_en_i) & ~grant_q);

    // Grant/release state machine with beat and idle accounting.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (lo_vld) begin
                    state_d = BUSY;
                    for (int j = 0; j < NUM_PORTS; j++) begin
                        grant_d[j] = (sel == PW'(j));
                    end
                    owner_d = sel;
                    last_d  = sel;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            BUSY: begin
                if (!own_req || burst_done || idle_expire) begin
                    // owner_q deliberately holds its value through idle.
                    state_d = IDLE;
                    grant_d = '0;
                end else if (beat) begin
                    beat_d = beat_q + 1'b1;
                    idle_d = '0;
                end else if (TIMEOUT != 0) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; async reset leaves port 0 first in rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
            beat_q  <= '0;
            idle_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            drop_q  <= drop_d;
        end
    end

    assign grant_o   = grant_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy;
    assign drop_o    = drop_q;
    assign timeout_o = idle_expire;

endmodule
